// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared 7-segment glyph definitions used by both the hex-to-segment encoder
//   and the segment-to-hex scan decoder.
//   Patterns are active-low, ordered g..a in bits [6:0]; a 0 bit lights that segment.
//   SEG_DP is the bit position of the decimal point on the 8-bit segment bus.
package seg7_pkg;

  localparam int SEG_DP = 7;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_patt_to_hex.sv
// seg7_patt_to_hex
//   Combinational inverse of the hex-to-segment encoder.
//   Ports:
//     patt    in  7  active-low segment pattern, g..a
//     nibble  out 4  decoded hex value (0 when not a legal hex glyph)
//     legal   out 1  pattern is one of the sixteen hex glyphs
//     blank   out 1  pattern is the all-dark glyph
module seg7_patt_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] patt,
  output logic [3:0] nibble,
  output logic       legal,
  output logic       blank
);

  always_comb begin
    nibble = 4'h0;
    legal  = 1'b1;
    blank  = 1'b0;
    case (patt)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: begin
        legal = 1'b0;
        blank = 1'b1;
      end
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
//   Reads back a multiplexed active-low 7-segment display bus and rebuilds the
//   hex word being shown, one settled digit at a time.
//   Ports:
//     clk, rst     clock and synchronous active-high reset
//     an           active-low digit selects, bit i low selects digit i
//     seg          active-low segments, [7]=dp, [6:0]=g..a
//     value        reconstructed word, digit i in value[4i+3:4i]
//     digit_valid  last capture of digit i was a legal hex glyph
//     dp           decimal point was lit on last capture of digit i
//     frame_done   one-cycle pulse when every digit has been captured since last pulse
//     err          one-cycle pulse when a captured glyph is neither hex nor blank
//     err_digit    digit index of the most recent err (held)
//     err_patt     segment pattern of the most recent err (held)
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DIGITS-1:0]         an,
  input  logic [7:0]                seg,
  output logic [4*DIGITS-1:0]       value,
  output logic [DIGITS-1:0]         digit_valid,
  output logic [DIGITS-1:0]         dp,
  output logic                      frame_done,
  output logic                      err,
  output logic [$clog2(DIGITS)-1:0] err_digit,
  output logic [6:0]                err_patt
);

  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  logic [DIGITS-1:0] an_sync  [SYNC_STAGES];
  logic [7:0]        seg_sync [SYNC_STAGES];
  logic [DIGITS-1:0] an_s, an_prev, sel;
  logic [7:0]        seg_s, seg_prev;
  logic [CW-1:0]     cnt;
  logic [DIGITS-1:0] seen, seen_next;
  logic [IW-1:0]     idx;
  logic              one_low, stable, capture;
  logic [3:0]        nibble;
  logic              legal, blank;

  // Sync chain resets to all-ones so the bus looks like a dark display.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        an_sync[s]  <= '1;
        seg_sync[s] <= '1;
      end
    end else begin
      an_sync[0]  <= an;
      seg_sync[0] <= seg;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        an_sync[s]  <= an_sync[s-1];
        seg_sync[s] <= seg_sync[s-1];
      end
    end
  end

  assign an_s  = an_sync[SYNC_STAGES-1];
  assign seg_s = seg_sync[SYNC_STAGES-1];

  // Exactly one select low: the inverted select word is a nonzero power of two.
  assign sel     = ~an_s;
  assign one_low = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  assign stable  = one_low && (an_s == an_prev) && (seg_s == seg_prev);
  assign capture = stable && (cnt == CW'(SETTLE_CYCLES - 1));

  always_comb begin
    idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel[i]) idx = IW'(i);
    end
  end

  assign seen_next = seen | (DIGITS'(1) << idx);

  seg7_patt_to_hex u_dec (
    .patt   (seg_s[6:0]),
    .nibble (nibble),
    .legal  (legal),
    .blank  (blank)
  );

  // Saturating settle counter; a capture fires only on the step into saturation,
  // so a held digit is read exactly once until the bus moves again.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_prev  <= '1;
      seg_prev <= '1;
      cnt      <= '0;
    end else begin
      an_prev  <= an_s;
      seg_prev <= seg_s;
      if (!stable)
        cnt <= '0;
      else if (cnt != CW'(SETTLE_CYCLES))
        cnt <= cnt + 1'b1;
    end
  end

  // Capture registers and the per-frame seen mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      value       <= '0;
      digit_valid <= '0;
      dp          <= '0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
      err_digit   <= '0;
      err_patt    <= '0;
      seen        <= '0;
    end else begin
      frame_done <= 1'b0;
      err        <= 1'b0;
      if (capture) begin
        dp[idx]             <= ~seg_s[SEG_DP];
        value[idx*4 +: 4]   <= legal ? nibble : 4'h0;
        digit_valid[idx]    <= legal;
        if (!legal && !blank) begin
          err       <= 1'b1;
          err_digit <= idx;
          err_patt  <= seg_s[6:0];
        end
        if (seen_next == '1) begin
          frame_done <= 1'b1;
          seen       <= '0;
        end else begin
          seen <= seen_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder
//   Self-checking bench for seg7_scan_decoder. A glyph-table reference model
//   tracks what the display reader should report after each settled digit.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic [31:0] value;
  logic [7:0]  digit_valid, dp;
  logic        frame_done, err;
  logic [2:0]  err_digit;
  logic [6:0]  err_patt;

  int vectors = 0;
  int miscompares = 0;

  int frame_cnt = 0;
  int err_cnt = 0;
  int err_wide = 0;
  logic err_prev = 1'b0;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [3:0] m_nib [8];
  logic [7:0] m_valid, m_dp, m_seen;
  logic [2:0] m_err_digit;
  logic [6:0] m_err_patt;
  int         m_frames, m_errs;

  seg7_scan_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .an          (an),
    .seg         (seg),
    .value       (value),
    .digit_valid (digit_valid),
    .dp          (dp),
    .frame_done  (frame_done),
    .err         (err),
    .err_digit   (err_digit),
    .err_patt    (err_patt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (frame_done === 1'b1) frame_cnt++;
    if (err === 1'b1) begin
      err_cnt++;
      if (err_prev) err_wide++;
    end
    err_prev = (err === 1'b1);
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_nib[i] = 4'h0;
    m_valid = '0; m_dp = '0; m_seen = '0;
    m_err_digit = '0; m_err_patt = '0;
  endtask

  task automatic model_capture(input int d, input logic [7:0] s);
    int hit;
    hit = -1;
    for (int n = 0; n < 16; n++) if (glyph[n] == s[6:0]) hit = n;
    m_dp[d] = ~s[7];
    if (hit >= 0) begin
      m_nib[d] = 4'(hit);
      m_valid[d] = 1'b1;
    end else begin
      m_nib[d] = 4'h0;
      m_valid[d] = 1'b0;
      if (s[6:0] != 7'h7F) begin
        m_errs++;
        m_err_digit = 3'(d);
        m_err_patt = s[6:0];
      end
    end
    m_seen[d] = 1'b1;
    if (m_seen == 8'hFF) begin
      m_frames++;
      m_seen = '0;
    end
  endtask

  function automatic logic [31:0] model_value();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[4*i +: 4] = m_nib[i];
    return v;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Show one digit long enough to settle, then go dark so a repeat is a new capture.
  task automatic scan_digit(input int d, input logic [7:0] s, input int hold);
    @(negedge clk);
    an = ~(8'(1) << d);
    seg = s;
    idle(hold);
    an = 8'hFF;
    seg = 8'hFF;
    idle(3);
    model_capture(d, s);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    idle(n);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; an = 8'h00; seg = 8'h00;
    model_reset();
    idle(3);
    vectors++;
    if ({value, digit_valid, dp, frame_done, err, err_digit, err_patt} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got value=%h valid=%h dp=%h fd=%b err=%b ed=%0d ep=%h, want all 0",
               value, digit_valid, dp, frame_done, err, err_digit, err_patt);
    end
    rst = 1'b0;
    an = 8'hFF; seg = 8'hFF;
    idle(6);
    vectors++;
    if (frame_cnt !== 0 || err_cnt !== 0) begin
      miscompares++;
      $display("[TB] FAIL reset_pulses: got frames=%0d errs=%0d, want 0 0", frame_cnt, err_cnt);
    end
  endtask

  task automatic test_scan_fixed();
    int f0;
    f0 = frame_cnt;
    for (int d = 0; d < 8; d++) scan_digit(d, {1'b1, glyph[d+1]}, 10);
    vectors++;
    if (value !== 32'h87654321) begin
      miscompares++;
      $display("[TB] FAIL scan_value: got %h want 87654321", value);
    end
    vectors++;
    if (digit_valid !== 8'hFF || dp !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL scan_flags: got valid=%h dp=%h want FF 00", digit_valid, dp);
    end
    vectors++;
    if (frame_cnt - f0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL scan_frame: got %0d pulses want 1", frame_cnt - f0);
    end
  endtask

  task automatic test_glitch();
    int f0, e0;
    f0 = frame_cnt; e0 = err_cnt;
    @(negedge clk);
    an = 8'hFE; seg = 8'hC0;
    idle(3);
    an = 8'hFF; seg = 8'hFF;
    idle(8);
    vectors++;
    if (value !== model_value()) begin
      miscompares++;
      $display("[TB] FAIL glitch_short: got %h want %h", value, model_value());
    end
    an = 8'hFC; seg = 8'hC0;
    idle(20);
    an = 8'hFF; seg = 8'hFF;
    idle(6);
    vectors++;
    if (value !== model_value() || digit_valid !== m_valid) begin
      miscompares++;
      $display("[TB] FAIL glitch_multi: got %h/%h want %h/%h", value, digit_valid, model_value(), m_valid);
    end
    vectors++;
    if (frame_cnt !== f0 || err_cnt !== e0) begin
      miscompares++;
      $display("[TB] FAIL glitch_pulses: got frames+%0d errs+%0d want 0 0", frame_cnt - f0, err_cnt - e0);
    end
  endtask

  task automatic test_blank();
    int e0;
    e0 = err_cnt;
    scan_digit(3, 8'h7F, 10);
    vectors++;
    if (value[15:12] !== 4'h0 || digit_valid[3] !== 1'b0 || dp[3] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL blank_digit3: got nib=%h valid=%b dp=%b want 0 0 1", value[15:12], digit_valid[3], dp[3]);
    end
    vectors++;
    if (err_cnt !== e0) begin
      miscompares++;
      $display("[TB] FAIL blank_err: got %0d err pulses want 0", err_cnt - e0);
    end
  endtask

  task automatic test_illegal();
    int e0, w0;
    e0 = err_cnt; w0 = err_wide;
    scan_digit(5, 8'h55, 10);
    vectors++;
    if (err_cnt - e0 !== 1 || err_wide !== w0) begin
      miscompares++;
      $display("[TB] FAIL illegal_pulse: got %0d err cycles want 1 single-cycle", err_cnt - e0);
    end
    vectors++;
    if (err_digit !== 3'd5 || err_patt !== 7'h55 || digit_valid[5] !== 1'b0 || value[23:20] !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL illegal_fields: got ed=%0d ep=%h valid5=%b nib=%h want 5 55 0 0",
               err_digit, err_patt, digit_valid[5], value[23:20]);
    end
  endtask

  task automatic test_reset_midframe();
    int f0;
    do_reset(2);
    for (int d = 0; d < 4; d++) scan_digit(d, {1'b1, glyph[d]}, 10);
    do_reset(2);
    f0 = frame_cnt;
    for (int d = 0; d < 7; d++) scan_digit(d, {1'b0, glyph[15-d]}, 10);
    vectors++;
    if (frame_cnt !== f0) begin
      miscompares++;
      $display("[TB] FAIL midreset_early: got %0d frames after 7 digits want 0", frame_cnt - f0);
    end
    scan_digit(7, {1'b0, glyph[8]}, 10);
    vectors++;
    if (frame_cnt - f0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL midreset_frame: got %0d frames want 1", frame_cnt - f0);
    end
    vectors++;
    if (value !== 32'h89ABCDEF || dp !== 8'hFF) begin
      miscompares++;
      $display("[TB] FAIL midreset_value: got %h dp=%h want 89abcdef FF", value, dp);
    end
  endtask

  task automatic test_random();
    int f0, e0, d, kind;
    logic [7:0] s;
    logic [6:0] p;
    bit ok;
    f0 = frame_cnt - m_frames;
    e0 = err_cnt - m_errs;
    for (int step = 0; step < 60; step++) begin
      d = $urandom_range(0, 7);
      kind = $urandom_range(0, 9);
      s[7] = 1'($urandom);
      if (kind == 0) begin
        s[6:0] = 7'h7F;
      end else if (kind == 1) begin
        ok = 1'b0;
        p = '0;
        while (!ok) begin
          p = 7'($urandom);
          ok = (p != 7'h7F);
          for (int n = 0; n < 16; n++) if (glyph[n] == p) ok = 1'b0;
        end
        s[6:0] = p;
      end else begin
        s[6:0] = glyph[$urandom_range(0, 15)];
      end
      scan_digit(d, s, $urandom_range(8, 12));
      vectors++;
      if (value !== model_value() || digit_valid !== m_valid || dp !== m_dp) begin
        miscompares++;
        $display("[TB] FAIL rand_fields step %0d: got %h/%h/%h want %h/%h/%h",
                 step, value, digit_valid, dp, model_value(), m_valid, m_dp);
      end
      vectors++;
      if (frame_cnt - f0 !== m_frames || err_cnt - e0 !== m_errs) begin
        miscompares++;
        $display("[TB] FAIL rand_pulses step %0d: got frames=%0d errs=%0d want %0d %0d",
                 step, frame_cnt - f0, err_cnt - e0, m_frames, m_errs);
      end
      vectors++;
      if (m_errs > 0 && (err_digit !== m_err_digit || err_patt !== m_err_patt)) begin
        miscompares++;
        $display("[TB] FAIL rand_errinfo step %0d: got %0d/%h want %0d/%h",
                 step, err_digit, err_patt, m_err_digit, m_err_patt);
      end
    end
  endtask

  initial begin
    m_frames = 0;
    m_errs = 0;
    test_reset();
    test_scan_fixed();
    test_glitch();
    test_blank();
    test_illegal();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
